axi4_burst_addr_gen: RTL and testbench

Per-beat address and byte-strobe generator for AXI4 bursts, parametrised in address, data, length and ID width, supporting FIXED, INCR and WRAP bursts and every transfer size up to the full data bus. It accepts one AW/AR-style command and emits one beat descriptor per transfer over a valid/ready handshake. Master drivers and slave memory models instantiate it to compute beat addresses and strobes. Illegal commands are flagged and produce no beats.

---
 rtl/axi4_burst_addr_gen_pkg.sv | 39 +++
 rtl/axi4_burst_addr_gen_if.sv | 37 +++
 rtl/axi4_beat_strobe_gen.sv | 53 +++++
 rtl/axi4_burst_addr_gen.sv | 144 ++++++++++++++
 tb/tb_axi4_burst_addr_gen.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_burst_addr_gen_pkg.sv
// rtl/axi4_burst_addr_gen_pkg.sv - shared burst/size encodings, widths and boundary constants
package axi4_burst_addr_gen_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED    = 2'b00,
    BURST_INCR     = 2'b01,
    BURST_WRAP     = 2'b10,
    BURST_RESERVED = 2'b11
  } burst_e;

  typedef enum logic [2:0] {
    SIZE_1B   = 3'd0,
    SIZE_2B   = 3'd1,
    SIZE_4B   = 3'd2,
    SIZE_8B   = 3'd3,
    SIZE_16B  = 3'd4,
    SIZE_32B  = 3'd5,
    SIZE_64B  = 3'd6,
    SIZE_128B = 3'd7
  } size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_LEN_WIDTH  = 8;
  localparam int DEF_ID_WIDTH   = 4;
  localparam int STROBE_WIDTH   = DEF_DATA_WIDTH / 8;
  localparam int BOUNDARY_4KB   = 4096;
  localparam int BOUNDARY_LSB   = 12;

  function automatic int strobe_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/axi4_burst_addr_gen_if.sv
// rtl/axi4_burst_addr_gen_if.sv - command and beat descriptor bundle
interface axi4_burst_addr_gen_if #(
  parameter int ADDR_WIDTH = axi4_burst_addr_gen_pkg::DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = axi4_burst_addr_gen_pkg::DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = axi4_burst_addr_gen_pkg::DEF_LEN_WIDTH,
  parameter int ID_WIDTH   = axi4_burst_addr_gen_pkg::DEF_ID_WIDTH
) ();
  import axi4_burst_addr_gen_pkg::*;

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [ID_WIDTH-1:0]     cmd_id;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [LEN_WIDTH-1:0]    cmd_len;
  logic [2:0]              cmd_size;
  burst_e                  cmd_burst;
  logic                    cmd_err;

  logic                    beat_valid;
  logic                    beat_ready;
  logic [ID_WIDTH-1:0]     beat_id;
  logic [ADDR_WIDTH-1:0]   beat_addr;
  logic [DATA_WIDTH/8-1:0] beat_strb;
  logic [LEN_WIDTH-1:0]    beat_idx;
  logic                    beat_last;

  modport master (
    output cmd_valid, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_ready,
    input  cmd_ready, cmd_err, beat_valid, beat_id, beat_addr, beat_strb, beat_idx, beat_last
  );

  modport slave (
    input  cmd_valid, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_ready,
    output cmd_ready, cmd_err, beat_valid, beat_id, beat_addr, beat_strb, beat_idx, beat_last
  );

endinterface

// File: rtl/axi4_beat_strobe_gen.sv
// rtl/axi4_beat_strobe_gen.sv - next beat address and byte-lane strobes for one address
module axi4_beat_strobe_gen
  import axi4_burst_addr_gen_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int STRB_WIDTH = STROBE_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [2:0]            size_i,
  input  burst_e                burst_i,
  input  logic [ADDR_WIDTH-1:0] wrap_lower_i,
  input  logic [ADDR_WIDTH-1:0] wrap_total_i,
  output logic [STRB_WIDTH-1:0] cur_strb_o,
  output logic [ADDR_WIDTH-1:0] next_addr_o,
  output logic [STRB_WIDTH-1:0] next_strb_o
);

  logic [ADDR_WIDTH-1:0] bytes_c;
  logic [ADDR_WIDTH-1:0] aligned_c;
  logic [ADDR_WIDTH-1:0] step_c;

  // Lanes from the address's own lane up to the top lane of its aligned slot.
  function automatic logic [STRB_WIDTH-1:0] lane_mask(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [2:0] sz);
    logic [ADDR_WIDTH-1:0] nbytes;
    logic [ADDR_WIDTH-1:0] lo;
    logic [ADDR_WIDTH-1:0] hi;
    logic [STRB_WIDTH-1:0] m;
    nbytes = ADDR_WIDTH'(1) << sz;
    lo     = a & ADDR_WIDTH'(STRB_WIDTH - 1);
    hi     = ((a & ~(nbytes - ADDR_WIDTH'(1))) & ADDR_WIDTH'(STRB_WIDTH - 1)) + nbytes - ADDR_WIDTH'(1);
    for (int i = 0; i < STRB_WIDTH; i++) begin
      m[i] = (ADDR_WIDTH'(i) >= lo) && (ADDR_WIDTH'(i) <= hi);
    end
    return m;
  endfunction

  always_comb begin
    bytes_c     = ADDR_WIDTH'(1) << size_i;
    aligned_c   = addr_i & ~(bytes_c - ADDR_WIDTH'(1));
    step_c      = addr_i + bytes_c;
    next_addr_o = addr_i;
    case (burst_i)
      BURST_INCR: next_addr_o = aligned_c + bytes_c;
      BURST_WRAP: next_addr_o = (step_c == wrap_lower_i + wrap_total_i) ? wrap_lower_i : step_c;
      default:    next_addr_o = addr_i;
    endcase
  end

  assign cur_strb_o  = lane_mask(addr_i, size_i);
  assign next_strb_o = lane_mask(next_addr_o, size_i);

endmodule

// File: rtl/axi4_burst_addr_gen.sv
// rtl/axi4_burst_addr_gen.sv - AXI4 burst command to per-beat address/strobe descriptors
module axi4_burst_addr_gen
  import axi4_burst_addr_gen_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter int ID_WIDTH   = DEF_ID_WIDTH
) (
  input logic                  aclk,
  input logic                  aresetn,
  axi4_burst_addr_gen_if.slave bus
);

  localparam int STRB_W = strobe_width(DATA_WIDTH);
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  state_e               state_q;
  logic                 cmd_ready_q, cmd_err_q, beat_valid_q, beat_last_q;
  addr_t                beat_addr_q, wrap_lower_q, wrap_total_q;
  logic [STRB_W-1:0]    beat_strb_q;
  logic [LEN_WIDTH-1:0] beat_idx_q, len_q;
  logic [ID_WIDTH-1:0]  beat_id_q;
  logic [2:0]           size_q;
  burst_e               burst_q;

  addr_t                bytes_c, aligned_c, span_c, incr_end_c, gen_addr_c, next_addr_c;
  logic                 illegal_c;
  logic [2:0]           gen_size_c;
  burst_e               gen_burst_c;
  logic [STRB_W-1:0]    cur_strb_c, next_strb_c;
  logic [LEN_WIDTH-1:0] next_idx_c;

  // span_c is both the INCR footprint and the WRAP container size.
  always_comb begin
    bytes_c    = addr_t'(1) << bus.cmd_size;
    aligned_c  = bus.cmd_addr & ~(bytes_c - addr_t'(1));
    span_c     = (addr_t'(bus.cmd_len) + addr_t'(1)) << bus.cmd_size;
    incr_end_c = aligned_c + span_c - addr_t'(1);
    illegal_c  = 1'b0;
    if ((32'd1 << bus.cmd_size) > 32'(STRB_W))
      illegal_c = 1'b1;
    if (bus.cmd_burst == BURST_RESERVED)
      illegal_c = 1'b1;
    if (bus.cmd_burst == BURST_WRAP &&
        !(bus.cmd_len inside {LEN_WIDTH'(1), LEN_WIDTH'(3), LEN_WIDTH'(7), LEN_WIDTH'(15)}))
      illegal_c = 1'b1;
    if (bus.cmd_burst == BURST_WRAP && (bus.cmd_addr & (bytes_c - addr_t'(1))) != '0)
      illegal_c = 1'b1;
    if (bus.cmd_burst == BURST_INCR &&
        bus.cmd_addr[ADDR_WIDTH-1:BOUNDARY_LSB] != incr_end_c[ADDR_WIDTH-1:BOUNDARY_LSB])
      illegal_c = 1'b1;
  end

  // One generator: in IDLE it strobes the incoming start address, in RUN it steps the current beat.
  assign gen_addr_c  = (state_q == ST_RUN) ? beat_addr_q : bus.cmd_addr;
  assign gen_size_c  = (state_q == ST_RUN) ? size_q      : bus.cmd_size;
  assign gen_burst_c = (state_q == ST_RUN) ? burst_q     : bus.cmd_burst;
  assign next_idx_c  = beat_idx_q + LEN_WIDTH'(1);

  axi4_beat_strobe_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .STRB_WIDTH (STRB_W)
  ) u_strobe (
    .addr_i       (gen_addr_c),
    .size_i       (gen_size_c),
    .burst_i      (gen_burst_c),
    .wrap_lower_i (wrap_lower_q),
    .wrap_total_i (wrap_total_q),
    .cur_strb_o   (cur_strb_c),
    .next_addr_o  (next_addr_c),
    .next_strb_o  (next_strb_c)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      cmd_ready_q  <= 1'b1;
      cmd_err_q    <= 1'b0;
      beat_valid_q <= 1'b0;
      beat_last_q  <= 1'b0;
      beat_addr_q  <= '0;
      beat_strb_q  <= '0;
      beat_idx_q   <= '0;
      beat_id_q    <= '0;
      len_q        <= '0;
      size_q       <= '0;
      burst_q      <= BURST_FIXED;
      wrap_lower_q <= '0;
      wrap_total_q <= '0;
    end else begin
      cmd_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            if (illegal_c) begin
              cmd_err_q <= 1'b1;
            end else begin
              state_q      <= ST_RUN;
              cmd_ready_q  <= 1'b0;
              beat_valid_q <= 1'b1;
              beat_addr_q  <= bus.cmd_addr;
              beat_strb_q  <= cur_strb_c;
              beat_idx_q   <= '0;
              beat_id_q    <= bus.cmd_id;
              beat_last_q  <= (bus.cmd_len == '0);
              len_q        <= bus.cmd_len;
              size_q       <= bus.cmd_size;
              burst_q      <= bus.cmd_burst;
              wrap_lower_q <= bus.cmd_addr & ~(span_c - addr_t'(1));
              wrap_total_q <= span_c;
            end
          end
        end
        ST_RUN: begin
          if (bus.beat_ready) begin
            if (beat_last_q) begin
              state_q      <= ST_IDLE;
              cmd_ready_q  <= 1'b1;
              beat_valid_q <= 1'b0;
              beat_last_q  <= 1'b0;
            end else begin
              beat_addr_q <= next_addr_c;
              beat_strb_q <= next_strb_c;
              beat_idx_q  <= next_idx_c;
              beat_last_q <= (next_idx_c == len_q);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.cmd_err    = cmd_err_q;
  assign bus.beat_valid = beat_valid_q;
  assign bus.beat_id    = beat_id_q;
  assign bus.beat_addr  = beat_addr_q;
  assign bus.beat_strb  = beat_strb_q;
  assign bus.beat_idx   = beat_idx_q;
  assign bus.beat_last  = beat_last_q;

endmodule

// File: tb/tb_axi4_burst_addr_gen.sv
// tb/tb_axi4_burst_addr_gen.sv - randomized and directed bench against a burst-list reference model
module tb_axi4_burst_addr_gen;
  import axi4_burst_addr_gen_pkg::*;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  axi4_burst_addr_gen_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .LEN_WIDTH(8), .ID_WIDTH(4)) bus ();

  axi4_burst_addr_gen #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .LEN_WIDTH(8), .ID_WIDTH(4)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  typedef struct {
    logic [15:0] addr;
    logic [3:0]  strb;
    logic [7:0]  idx;
    logic        last;
    logic [3:0]  id;
  } beat_t;

  beat_t       exp_q[$];
  logic        err_exp = 1'b0;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] got_addr[$];
  logic [3:0]  got_strb[$];
  logic        got_last[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic bit is_illegal(input logic [15:0] addr, input logic [7:0] len,
                                    input logic [2:0] size, input logic [1:0] burst);
    int bytes, a, al, l, last_byte;
    bytes = 1 << size;
    a = addr;
    l = len;
    al = (a / bytes) * bytes;
    if (bytes > 4) return 1'b1;
    if (burst == 2'd3) return 1'b1;
    if (burst == 2'd2 && !(l == 1 || l == 3 || l == 7 || l == 15)) return 1'b1;
    if (burst == 2'd2 && (a % bytes) != 0) return 1'b1;
    if (burst == 2'd1) begin
      last_byte = (al + (l + 1) * bytes - 1) % 65536;
      if ((a >> 12) != (last_byte >> 12)) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [3:0] strb_of(input int a, input int bytes);
    int lo, hi;
    logic [3:0] m;
    lo = a % 4;
    hi = ((a / bytes) * bytes) % 4 + bytes - 1;
    m = '0;
    for (int k = lo; k <= hi; k++) m[k] = 1'b1;
    return m;
  endfunction

  // Whole burst expanded up front: beat n's address is a closed-form function of n.
  function automatic void build(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                                input logic [2:0] size, input logic [1:0] burst);
    int bytes, a0, al, total, lower, a, l;
    beat_t b;
    bytes = 1 << size;
    a0 = addr;
    l = len;
    al = (a0 / bytes) * bytes;
    total = bytes * (l + 1);
    lower = (a0 / total) * total;
    for (int n = 0; n <= l; n++) begin
      case (burst)
        2'd0:    a = a0;
        2'd1:    a = (n == 0) ? a0 : (al + n * bytes) % 65536;
        default: a = lower + ((a0 - lower) + n * bytes) % total;
      endcase
      b.addr = a[15:0];
      b.strb = strb_of(a, bytes);
      b.idx  = n[7:0];
      b.last = (n == l);
      b.id   = id;
      exp_q.push_back(b);
    end
  endfunction

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      exp_q.delete();
      err_exp <= 1'b0;
    end else begin
      err_exp <= 1'b0;
      if (exp_q.size() != 0) begin
        if (bus.beat_ready) void'(exp_q.pop_front());
      end else if (bus.cmd_valid) begin
        if (is_illegal(bus.cmd_addr, bus.cmd_len, bus.cmd_size, bus.cmd_burst))
          err_exp <= 1'b1;
        else
          build(bus.cmd_id, bus.cmd_addr, bus.cmd_len, bus.cmd_size, bus.cmd_burst);
      end
    end
  end

  always @(negedge aclk) begin
    if (!aresetn) begin
      check("rst_ctrl", {28'd0, bus.cmd_ready, bus.cmd_err, bus.beat_valid, bus.beat_last}, 32'h8);
      check("rst_data", {bus.beat_addr, bus.beat_strb, bus.beat_idx, bus.beat_id}, 32'h0);
    end else begin
      check("cmd_ready", {31'd0, bus.cmd_ready}, {31'd0, exp_q.size() == 0});
      check("beat_valid", {31'd0, bus.beat_valid}, {31'd0, exp_q.size() != 0});
      check("cmd_err", {31'd0, bus.cmd_err}, {31'd0, err_exp});
      if (exp_q.size() != 0 && bus.beat_valid) begin
        check("beat_addr", {16'd0, bus.beat_addr}, {16'd0, exp_q[0].addr});
        check("beat_strb", {28'd0, bus.beat_strb}, {28'd0, exp_q[0].strb});
        check("beat_idx_last_id", {19'd0, bus.beat_idx, bus.beat_last, bus.beat_id},
              {19'd0, exp_q[0].idx, exp_q[0].last, exp_q[0].id});
      end
      if (bus.beat_valid && bus.beat_ready) begin
        got_addr.push_back(bus.beat_addr);
        got_strb.push_back(bus.beat_strb);
        got_last.push_back(bus.beat_last);
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                      input logic [2:0] size, input logic [1:0] burst);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) check("send_timeout", 32'd1, 32'd0);
    bus.cmd_valid = 1'b1;
    bus.cmd_id    = id;
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    bus.cmd_size  = size;
    bus.cmd_burst = burst_e'(burst);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain(input bit rnd);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      if (rnd) bus.beat_ready = ($urandom_range(0, 3) != 0);
      tick();
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'd1, 32'd0);
    bus.beat_ready = 1'b1;
  endtask

  task automatic clear_got();
    got_addr.delete();
    got_strb.delete();
    got_last.delete();
  endtask

  task automatic expect_seq(input string nm, input int n, input logic [15:0] ea[4], input logic [3:0] es[4]);
    check({nm, "_count"}, got_addr.size(), n);
    for (int k = 0; k < n; k++) begin
      if (k < got_addr.size()) begin
        check({nm, "_addr"}, {16'd0, got_addr[k]}, {16'd0, ea[k]});
        check({nm, "_strb"}, {28'd0, got_strb[k]}, {28'd0, es[k]});
        check({nm, "_last"}, {31'd0, got_last[k]}, {31'd0, k == n - 1});
      end
    end
  endtask

  task automatic expect_illegal(input string nm, input logic [15:0] addr, input logic [7:0] len,
                                input logic [2:0] size, input logic [1:0] burst);
    send(4'h3, addr, len, size, burst);
    check({nm, "_err"}, {31'd0, bus.cmd_err}, 32'd1);
    check({nm, "_novalid"}, {31'd0, bus.beat_valid}, 32'd0);
    check({nm, "_ready"}, {31'd0, bus.cmd_ready}, 32'd1);
    tick();
    check({nm, "_err_gone"}, {31'd0, bus.cmd_err}, 32'd0);
  endtask

  logic [15:0] ea[4];
  logic [3:0]  es[4];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  rb;
    logic [2:0]  rs;
    logic [7:0]  rl;
    logic [15:0] ra;
    aresetn        = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_id     = '0;
    bus.cmd_addr   = '0;
    bus.cmd_len    = '0;
    bus.cmd_size   = '0;
    bus.cmd_burst  = BURST_FIXED;
    bus.beat_ready = 1'b1;
    repeat (3) tick();
    aresetn = 1'b1;
    tick();

    clear_got();
    send(4'h5, 16'h0002, 8'd3, 3'd2, 2'd1);
    drain(1'b0);
    ea = '{16'h0002, 16'h0004, 16'h0008, 16'h000C};
    es = '{4'b1100, 4'b1111, 4'b1111, 4'b1111};
    expect_seq("incr", 4, ea, es);

    clear_got();
    send(4'h6, 16'h0038, 8'd3, 3'd2, 2'd2);
    drain(1'b0);
    ea = '{16'h0038, 16'h003C, 16'h0030, 16'h0034};
    es = '{4'b1111, 4'b1111, 4'b1111, 4'b1111};
    expect_seq("wrap", 4, ea, es);

    clear_got();
    send(4'h7, 16'h0101, 8'd2, 3'd0, 2'd0);
    drain(1'b0);
    ea = '{16'h0101, 16'h0101, 16'h0101, 16'h0000};
    es = '{4'b0010, 4'b0010, 4'b0010, 4'b0000};
    expect_seq("fixed", 3, ea, es);

    expect_illegal("ill_4k", 16'h0FF8, 8'd3, 3'd2, 2'd1);
    expect_illegal("ill_size", 16'h0000, 8'd1, 3'd3, 2'd1);
    expect_illegal("ill_wraplen", 16'h0040, 8'd2, 3'd2, 2'd2);

    clear_got();
    send(4'h5, 16'h0002, 8'd3, 3'd2, 2'd1);
    tick();
    bus.beat_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("bp_addr", {16'd0, bus.beat_addr}, 32'h0004);
      check("bp_strb_idx_valid", {19'd0, bus.beat_strb, bus.beat_idx, bus.beat_valid}, {19'd0, 4'hF, 8'd1, 1'b1});
      tick();
    end
    bus.beat_ready = 1'b1;
    drain(1'b0);
    ea = '{16'h0002, 16'h0004, 16'h0008, 16'h000C};
    es = '{4'b1100, 4'b1111, 4'b1111, 4'b1111};
    expect_seq("bp", 4, ea, es);

    send(4'h5, 16'h0002, 8'd3, 3'd2, 2'd1);
    tick();
    tick();
    check("pre_rst_idx", {24'd0, bus.beat_idx}, 32'd2);
    #1 aresetn = 1'b0;
    #1 check("async_rst_valid", {31'd0, bus.beat_valid}, 32'd0);
    tick();
    tick();
    aresetn = 1'b1;
    tick();
    check("post_rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
    clear_got();
    send(4'h1, 16'h0000, 8'd0, 3'd2, 2'd1);
    drain(1'b0);
    ea = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    es = '{4'b1111, 4'b0000, 4'b0000, 4'b0000};
    expect_seq("single", 1, ea, es);

    for (int it = 0; it < 250; it++) begin
      rb = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      rs = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      ra = 16'($urandom);
      if (rb == 2'd2) begin
        case ($urandom_range(0, 4))
          0: rl = 8'd1;
          1: rl = 8'd3;
          2: rl = 8'd7;
          3: rl = 8'd15;
          default: rl = 8'($urandom_range(0, 20));
        endcase
        if ($urandom_range(0, 4) != 0) ra = ra & ~((16'd1 << rs) - 16'd1);
      end else begin
        rl = 8'($urandom_range(0, 31));
      end
      send(4'($urandom), ra, rl, rs, rb);
      drain(1'b1);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
